// File: rtl/vga_plot_arbiter_if.sv
// Pixel-request bus between the game requesters and the plot arbiter, plus the
// registered pixel-write port that feeds vga_adapter.
interface vga_plot_arbiter_if;
  logic [2:0]  req;
  logic [23:0] req_x;
  logic [20:0] req_y;
  logic [8:0]  req_colour;
  logic [2:0]  grant;
  logic        clear_start;
  logic        clear_busy;
  logic        clear_done;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;

  // Requester side: presents pixels and clear requests.
  modport master (
    output req, req_x, req_y, req_colour, clear_start,
    input  grant, clear_busy, clear_done, x, y, colour, plot
  );

  // Arbiter side: grants requests and drives the pixel-write port.
  modport slave (
    input  req, req_x, req_y, req_colour, clear_start,
    output grant, clear_busy, clear_done, x, y, colour, plot
  );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Round-robin sharing of the vga_adapter pixel-write port among three requesters, with a
// full-screen clear sequencer that owns the port exclusively while it sweeps.
module vga_plot_arbiter #(
  parameter int unsigned WIDTH          = 160,
  parameter int unsigned HEIGHT         = 120,
  parameter logic [2:0]  CLEAR_COLOUR   = 3'b000,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input logic               clk,
  input logic               reset,
  vga_plot_arbiter_if.slave bus
);

  localparam logic [7:0] XLast = 8'(WIDTH - 1);
  localparam logic [6:0] YLast = 7'(HEIGHT - 1);

  typedef enum logic [0:0] {StArb, StClear} state_e;

  state_e      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [7:0]  cx_q, cx_d;
  logic [6:0]  cy_q, cy_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [2:0]  colour_q, colour_d;
  logic        plot_q, plot_d;
  logic        clear_done_q, clear_done_d;

  logic [2:0]  grant;
  logic [7:0]  px [3];
  logic [6:0]  py [3];
  logic [2:0]  pc [3];
  logic [1:0]  ord0, ord1, ord2;
  logic [1:0]  win_idx;
  logic        win_vld;
  logic        win_in_range;
  logic        sweep_last;

  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      px[i] = bus.req_x[8*i +: 8];
      py[i] = bus.req_y[7*i +: 7];
      pc[i] = bus.req_colour[3*i +: 3];
    end
  end

  // Scan order starts at ptr and wraps modulo 3.
  always_comb begin
    ord0    = ptr_q;
    ord1    = next_port(ord0);
    ord2    = next_port(ord1);
    win_vld = 1'b1;
    win_idx = ord0;
    if (bus.req[ord0]) begin
      win_idx = ord0;
    end else if (bus.req[ord1]) begin
      win_idx = ord1;
    end else if (bus.req[ord2]) begin
      win_idx = ord2;
    end else begin
      win_vld = 1'b0;
    end
  end

  assign win_in_range = (32'(px[win_idx]) < WIDTH) && (32'(py[win_idx]) < HEIGHT);
  assign sweep_last   = (cx_q == XLast) && (cy_q == YLast);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (CLEAR_ON_RESET) begin
        state_q <= StClear;
      end else begin
        state_q <= StArb;
      end
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StArb:   if (bus.clear_start) state_d = StClear;
      StClear: if (sweep_last)      state_d = StArb;
      default: state_d = StArb;
    endcase
  end

  // Output and datapath next-state logic.
  always_comb begin
    grant        = '0;
    x_d          = x_q;
    y_d          = y_q;
    colour_d     = colour_q;
    plot_d       = 1'b0;
    ptr_d        = ptr_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    clear_done_d = 1'b0;
    unique case (state_q)
      StArb: begin
        // A clear request pre-empts any pixel request presented in the same cycle.
        if (bus.clear_start) begin
          cx_d = '0;
          cy_d = '0;
        end else if (win_vld) begin
          grant[win_idx] = 1'b1;
          x_d            = px[win_idx];
          y_d            = py[win_idx];
          colour_d       = pc[win_idx];
          plot_d         = win_in_range;
          ptr_d          = next_port(win_idx);
        end
      end
      StClear: begin
        x_d      = cx_q;
        y_d      = cy_q;
        colour_d = CLEAR_COLOUR;
        plot_d   = 1'b1;
        if (sweep_last) begin
          cx_d         = '0;
          cy_d         = '0;
          clear_done_d = 1'b1;
        end else if (cx_q == XLast) begin
          cx_d = '0;
          cy_d = cy_q + 7'd1;
        end else begin
          cx_d = cx_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q        <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      plot_q       <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      plot_q       <= plot_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign bus.grant      = grant;
  assign bus.clear_busy = (state_q == StClear);
  assign bus.clear_done = clear_done_q;
  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.colour     = colour_q;
  assign bus.plot       = plot_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for vga_plot_arbiter: directed clear/arbitration scenarios on a clear-on-reset
// instance, and randomized arbitration against a reference model on a second instance.
module tb_vga_plot_arbiter;

  localparam int W    = 160;
  localparam int H    = 120;
  localparam int NPIX = W * H;

  logic clk = 1'b0;
  logic rst;
  logic rst0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vga_plot_arbiter_if bus ();
  vga_plot_arbiter_if bus0 ();

  vga_plot_arbiter #(
    .WIDTH         (W),
    .HEIGHT        (H),
    .CLEAR_COLOUR  (3'b000),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk  (clk),
    .reset(rst),
    .bus  (bus)
  );

  vga_plot_arbiter #(
    .WIDTH         (W),
    .HEIGHT        (H),
    .CLEAR_COLOUR  (3'b000),
    .CLEAR_ON_RESET(1'b0)
  ) dut0 (
    .clk  (clk),
    .reset(rst0),
    .bus  (bus0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [7:0] xv, input logic [6:0] yv,
                          input logic [2:0] cv);
    bus.req_x[8*p +: 8]      = xv;
    bus.req_y[7*p +: 7]      = yv;
    bus.req_colour[3*p +: 3] = cv;
  endtask

  // Observes a sweep on the main instance until clear_done (bounded); optionally pulses
  // clear_start once the given number of pixels has been seen.
  task automatic sweep_mon(input int restart_at, output int plots, output int busy_n,
                           output int done_n, output int seq_errs, output int gviol,
                           output logic [7:0] lx, output logic [6:0] ly);
    int cyc  = 0;
    bit done = 1'b0;
    plots = 0; busy_n = 0; done_n = 0; seq_errs = 0; gviol = 0; lx = '0; ly = '0;
    while (!done && cyc < NPIX + 50) begin
      if (bus.clear_busy === 1'b1) busy_n++;
      if (bus.clear_busy === 1'b1 && bus.grant !== 3'b000) gviol++;
      if (bus.plot === 1'b1) begin
        if (bus.x !== 8'(plots % W) || bus.y !== 7'(plots / W) || bus.colour !== 3'b000) begin
          if (seq_errs == 0)
            $display("first bad sweep pixel #%0d: got (%0d,%0d,%0d)", plots, bus.x, bus.y,
                     bus.colour);
          seq_errs++;
        end
        plots++;
        lx = bus.x;
        ly = bus.y;
        if (plots == restart_at) bus.clear_start = 1'b1;
      end
      if (bus.clear_done === 1'b1) begin
        done_n++;
        done = 1'b1;
      end
      if (!done) begin
        step();
        bus.clear_start = 1'b0;
        cyc++;
      end
    end
  endtask

  task automatic check_sweep(input string tag, input int restart_at);
    int plots, busy_n, done_n, seq_errs, gviol;
    logic [7:0] lx;
    logic [6:0] ly;
    sweep_mon(restart_at, plots, busy_n, done_n, seq_errs, gviol, lx, ly);
    checks++; if (plots !== NPIX) begin errors++;
      $display("FAIL %s plot_count got %0d want %0d", tag, plots, NPIX); end
    checks++; if (busy_n !== NPIX) begin errors++;
      $display("FAIL %s busy_cycles got %0d want %0d", tag, busy_n, NPIX); end
    checks++; if (done_n !== 1) begin errors++;
      $display("FAIL %s done_seen got %0d want 1", tag, done_n); end
    checks++; if (seq_errs !== 0) begin errors++;
      $display("FAIL %s pixel_sequence bad_pixels got %0d want 0", tag, seq_errs); end
    checks++; if (gviol !== 0) begin errors++;
      $display("FAIL %s grant_while_busy got %0d want 0", tag, gviol); end
    checks++; if (lx !== 8'd159 || ly !== 7'd119) begin errors++;
      $display("FAIL %s last_pixel got (%0d,%0d) want (159,119)", tag, lx, ly); end
    checks++; if (bus.clear_busy !== 1'b0) begin errors++;
      $display("FAIL %s busy_at_done got %b want 0", tag, bus.clear_busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1; rst0 = 1'b1;
    step(); step();
    checks++; if (bus.plot !== 1'b0 || bus.x !== 8'd0 || bus.y !== 7'd0 || bus.colour !== 3'd0)
      begin errors++; $display("FAIL reset_pixel got plot=%b (%0d,%0d,%0d) want 0 (0,0,0)",
                               bus.plot, bus.x, bus.y, bus.colour); end
    checks++; if (bus.clear_done !== 1'b0 || bus.grant !== 3'b000) begin errors++;
      $display("FAIL reset_done_grant got %b/%b want 0/000", bus.clear_done, bus.grant); end
    checks++; if (bus.clear_busy !== 1'b1) begin errors++;
      $display("FAIL reset_busy_cor1 got %b want 1", bus.clear_busy); end
    checks++; if (bus0.clear_busy !== 1'b0 || bus0.plot !== 1'b0) begin errors++;
      $display("FAIL reset_cor0 got busy=%b plot=%b want 0/0", bus0.clear_busy, bus0.plot); end
    rst = 1'b0; rst0 = 1'b0;
    check_sweep("reset_sweep", -1);
    step();
    checks++; if (bus.clear_done !== 1'b0) begin errors++;
      $display("FAIL done_pulse_width got %b want 0", bus.clear_done); end
  endtask

  task automatic test_round_robin();
    logic [2:0] gexp [4];
    logic [7:0] vexp [4];
    logic [2:0] cexp [4];
    gexp = '{3'b001, 3'b010, 3'b100, 3'b001};
    vexp = '{8'd5, 8'd6, 8'd7, 8'd5};
    cexp = '{3'b001, 3'b010, 3'b100, 3'b001};
    set_port(0, 8'd5, 7'd5, 3'b001);
    set_port(1, 8'd6, 7'd6, 3'b010);
    set_port(2, 8'd7, 7'd7, 3'b100);
    bus.req = 3'b111;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.grant !== gexp[k]) begin errors++;
        $display("FAIL rr_grant[%0d] got %b want %b", k, bus.grant, gexp[k]); end
      step();
      checks++;
      if (bus.plot !== 1'b1 || bus.x !== vexp[k] || bus.y !== 7'(vexp[k]) ||
          bus.colour !== cexp[k]) begin errors++;
        $display("FAIL rr_pixel[%0d] got %b (%0d,%0d,%0d) want 1 (%0d,%0d,%0d)", k, bus.plot,
                 bus.x, bus.y, bus.colour, vexp[k], vexp[k], cexp[k]); end
    end
    bus.req = 3'b000;
  endtask

  task automatic test_out_of_range();
    set_port(1, 8'd160, 7'd10, 3'b111);
    bus.req = 3'b010;
    #1;
    checks++; if (bus.grant !== 3'b010) begin errors++;
      $display("FAIL oor_grant got %b want 010", bus.grant); end
    step();
    checks++; if (bus.plot !== 1'b0) begin errors++;
      $display("FAIL oor_plot got %b want 0", bus.plot); end
    set_port(1, 8'd159, 7'd119, 3'b111);
    #1;
    checks++; if (bus.grant !== 3'b010) begin errors++;
      $display("FAIL edge_grant got %b want 010", bus.grant); end
    step();
    checks++; if (bus.plot !== 1'b1 || bus.x !== 8'd159 || bus.y !== 7'd119 || bus.colour !== 3'd7)
      begin errors++; $display("FAIL edge_pixel got %b (%0d,%0d,%0d) want 1 (159,119,7)",
                               bus.plot, bus.x, bus.y, bus.colour); end
    bus.req = 3'b000;
  endtask

  task automatic test_idle_hold();
    set_port(2, 8'd12, 7'd34, 3'b101);
    bus.req = 3'b100;
    #1;
    checks++; if (bus.grant !== 3'b100) begin errors++;
      $display("FAIL idle_p2_grant got %b want 100", bus.grant); end
    step();
    bus.req = 3'b000;
    #1;
    checks++; if (bus.grant !== 3'b000) begin errors++;
      $display("FAIL idle_grant got %b want 000", bus.grant); end
    step();
    checks++; if (bus.plot !== 1'b0 || bus.x !== 8'd12 || bus.y !== 7'd34 || bus.colour !== 3'd5)
      begin errors++; $display("FAIL idle_hold got %b (%0d,%0d,%0d) want 0 (12,34,5)",
                               bus.plot, bus.x, bus.y, bus.colour); end
    set_port(0, 8'd20, 7'd21, 3'b110);
    bus.req = 3'b001;
    #1;
    checks++; if (bus.grant !== 3'b001) begin errors++;
      $display("FAIL idle_p0_grant got %b want 001", bus.grant); end
    step();
    checks++; if (bus.plot !== 1'b1 || bus.x !== 8'd20 || bus.y !== 7'd21 || bus.colour !== 3'd6)
      begin errors++; $display("FAIL idle_p0_pixel got %b (%0d,%0d,%0d) want 1 (20,21,6)",
                               bus.plot, bus.x, bus.y, bus.colour); end
    bus.req = 3'b000;
  endtask

  task automatic test_clear_preempt();
    set_port(0, 8'd1, 7'd2, 3'b011);
    bus.req = 3'b001;
    bus.clear_start = 1'b1;
    #1;
    checks++; if (bus.grant !== 3'b000) begin errors++;
      $display("FAIL preempt_grant got %b want 000", bus.grant); end
    step();
    bus.clear_start = 1'b0;
    checks++; if (bus.clear_busy !== 1'b1 || bus.plot !== 1'b0) begin errors++;
      $display("FAIL preempt_busy got busy=%b plot=%b want 1/0", bus.clear_busy, bus.plot); end
    check_sweep("preempt_sweep", 100);
    checks++; if (bus.grant !== 3'b001) begin errors++;
      $display("FAIL resume_grant got %b want 001", bus.grant); end
    step();
    checks++; if (bus.plot !== 1'b1 || bus.x !== 8'd1 || bus.y !== 7'd2 || bus.colour !== 3'd3)
      begin errors++; $display("FAIL resume_pixel got %b (%0d,%0d,%0d) want 1 (1,2,3)",
                               bus.plot, bus.x, bus.y, bus.colour); end
    bus.req = 3'b000;
    step();
  endtask

  task automatic test_mid_sweep_reset();
    int seen = 0;
    int cyc  = 0;
    bus.clear_start = 1'b1; bus0.clear_start = 1'b1;
    step();
    bus.clear_start = 1'b0; bus0.clear_start = 1'b0;
    checks++; if (bus0.clear_busy !== 1'b1) begin errors++;
      $display("FAIL cor0_sweep_start got %b want 1", bus0.clear_busy); end
    while (seen < 5000 && cyc < 6000) begin
      step();
      cyc++;
      if (bus.plot === 1'b1) seen++;
    end
    checks++; if (seen !== 5000) begin errors++;
      $display("FAIL midreset_reach got %0d want 5000", seen); end
    rst = 1'b1; rst0 = 1'b1;
    step();
    checks++; if (bus.plot !== 1'b0 || bus.x !== 8'd0 || bus.y !== 7'd0 || bus.clear_busy !== 1'b1)
      begin errors++; $display("FAIL midreset_cor1 got plot=%b (%0d,%0d) busy=%b want 0 (0,0) 1",
                               bus.plot, bus.x, bus.y, bus.clear_busy); end
    checks++;
    if (bus0.plot !== 1'b0 || bus0.x !== 8'd0 || bus0.y !== 7'd0 || bus0.clear_busy !== 1'b0)
      begin errors++; $display("FAIL midreset_cor0 got plot=%b (%0d,%0d) busy=%b want 0 (0,0) 0",
                               bus0.plot, bus0.x, bus0.y, bus0.clear_busy); end
    rst = 1'b0; rst0 = 1'b0;
    check_sweep("restart_sweep", -1);
    checks++; if (bus0.clear_busy !== 1'b0 || bus0.plot !== 1'b0) begin errors++;
      $display("FAIL cor0_idle got busy=%b plot=%b want 0/0", bus0.clear_busy, bus0.plot); end
    step();
  endtask

  // Random arbitration on the no-clear instance against a rotate-and-scan model.
  task automatic test_random_arb();
    bit         pend [3];
    logic [7:0] dx [3];
    logic [6:0] dy [3];
    logic [2:0] dc [3];
    int         waitc [3];
    int         mptr = 0;
    int         max_wait = 0;
    int         win;
    logic [2:0] exp_grant;
    logic       exp_plot = 1'b0;
    logic [7:0] exp_x = '0;
    logic [6:0] exp_y = '0;
    logic [2:0] exp_c = '0;
    rst0 = 1'b1;
    step();
    rst0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pend[i] = 1'b0; waitc[i] = 0; dx[i] = '0; dy[i] = '0; dc[i] = '0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      checks++;
      if (bus0.plot !== exp_plot || bus0.x !== exp_x || bus0.y !== exp_y ||
          bus0.colour !== exp_c) begin errors++;
        $display("FAIL rand_pixel cyc %0d got %b (%0d,%0d,%0d) want %b (%0d,%0d,%0d)", cyc,
                 bus0.plot, bus0.x, bus0.y, bus0.colour, exp_plot, exp_x, exp_y, exp_c); end
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && $urandom_range(99, 0) < 60) begin
          pend[i] = 1'b1;
          dx[i] = 8'($urandom_range(175, 0));
          dy[i] = 7'($urandom_range(127, 0));
          dc[i] = 3'($urandom_range(7, 0));
        end
        bus0.req[i]              = pend[i];
        bus0.req_x[8*i +: 8]     = dx[i];
        bus0.req_y[7*i +: 7]     = dy[i];
        bus0.req_colour[3*i +: 3] = dc[i];
      end
      #1;
      win = -1;
      for (int k = 0; k < 3; k++) begin
        if (win < 0 && pend[(mptr + k) % 3]) win = (mptr + k) % 3;
      end
      exp_grant = (win < 0) ? 3'b000 : 3'(1 << win);
      checks++; if (bus0.grant !== exp_grant) begin errors++;
        $display("FAIL rand_grant cyc %0d got %b want %b", cyc, bus0.grant, exp_grant); end
      for (int i = 0; i < 3; i++) begin
        if (pend[i] && bus0.grant[i] !== 1'b1) begin
          waitc[i]++;
          if (waitc[i] > max_wait) max_wait = waitc[i];
        end else begin
          waitc[i] = 0;
        end
      end
      if (win >= 0) begin
        exp_x    = dx[win];
        exp_y    = dy[win];
        exp_c    = dc[win];
        exp_plot = (int'(dx[win]) < W) && (int'(dy[win]) < H);
        mptr     = (win + 1) % 3;
        pend[win] = 1'b0;
      end else begin
        exp_plot = 1'b0;
      end
      step();
    end
    checks++; if (max_wait > 2) begin errors++;
      $display("FAIL rand_fairness max_wait got %0d want <=2", max_wait); end
    bus0.req = 3'b000;
  endtask

  initial begin
    bus.req = '0; bus.req_x = '0; bus.req_y = '0; bus.req_colour = '0; bus.clear_start = 1'b0;
    bus0.req = '0; bus0.req_x = '0; bus0.req_y = '0; bus0.req_colour = '0;
    bus0.clear_start = 1'b0;
    rst = 1'b1; rst0 = 1'b1;
    test_reset();
    test_round_robin();
    test_out_of_range();
    test_idle_hold();
    test_clear_preempt();
    test_mid_sweep_reset();
    test_random_arb();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
